// File: rtl/parity_arbiter_pkg.sv
// Shared constants, state encoding and operation record for parity_arbiter.
package parity_arbiter_pkg;

   localparam int NREQ = 4;   // number of requesters, fixed
   localparam int DW   = 4;   // data width per request, fixed by parity4
   localparam int CW   = 8;   // odd-parity status counter width
   localparam int IDW  = 2;   // requester index width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   // One accepted request waiting for / inside the parity unit.
   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
   } op_t;

   // Index of the set bit of a one-hot vector (0 when empty).
   function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = IDW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/parity_arbiter_if.sv
// Request / response bus between the requesting stages, the consumer and
// the parity arbiter.
//
// Handshake rule for both directions: a transfer happens at a rising clock
// edge where valid and ready are both high. The sender holds valid and its
// payload stable until that edge; ready carries no obligation on its own.
interface parity_arbiter_if;

   logic [parity_arbiter_pkg::NREQ-1:0]                      req_valid;
   logic [parity_arbiter_pkg::NREQ*parity_arbiter_pkg::DW-1:0] req_data;
   logic [parity_arbiter_pkg::NREQ-1:0]                      req_ready;
   logic                                                     rsp_valid;
   logic                                                     rsp_ready;
   logic [parity_arbiter_pkg::IDW-1:0]                       rsp_id;
   logic [parity_arbiter_pkg::DW-1:0]                        rsp_data;
   logic [2:0]                                               rsp_prefix;

   // Arbiter side.
   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_prefix
   );

   // Requesters and response consumer side.
   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_prefix
   );

endinterface

// File: rtl/parity_arbiter_parity4.sv
// Shared 4-bit XOR-chain parity unit producing prefix parities e, f, g.
module parity4 (
   input  logic [3:0] d,
   output logic       e,
   output logic       f,
   output logic       g
);

   // Chained so each stage is the parity of all lower bits.
   assign e = d[0] ^ d[1];
   assign f = d[2] ^ e;
   assign g = d[3] ^ f;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter that shares one parity4 unit among four requesters
// and returns tagged responses through a valid/ready holding register.
module parity_arbiter
   import parity_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   parity_arbiter_if.slave   bus,
   output logic [CW-1:0]     odd_cnt,
   output logic              busy,
   output state_t            state_dbg
);

   state_t           state;
   op_t              op_reg;
   logic [IDW-1:0]   last_grant;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   accept_id;
   logic [DW-1:0]    accept_data;
   logic             par_e, par_f, par_g;

   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [DW-1:0]    rsp_data_q;
   logic [2:0]       rsp_prefix_q;

   // First valid requester found searching upward from last+1, wrapping.
   function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] valid,
                                                input logic [IDW-1:0]  last);
      logic [NREQ-1:0] g;
      logic [IDW-1:0]  idx;
      logic            found;
      g     = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = last + IDW'(k);
         if (!found && valid[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   // Grant is only offered while idle, so at most one operation is in flight.
   always_comb begin
      grant = '0;
      if (state == IDLE) grant = rr_grant(bus.req_valid, last_grant);
   end

   assign accept_id   = onehot_to_idx(grant);
   assign accept_data = bus.req_data[DW*accept_id +: DW];

   parity4 u_parity4 (
      .d (op_reg.data),
      .e (par_e),
      .f (par_f),
      .g (par_g)
   );

   // Sequencer: accept in IDLE, evaluate in CALC, hold the response in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         op_reg       <= '0;
         last_grant   <= IDW'(NREQ-1);
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_prefix_q <= '0;
         odd_cnt      <= '0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  op_reg.id   <= accept_id;
                  op_reg.data <= accept_data;
                  last_grant  <= accept_id;
                  busy        <= 1'b1;
                  state       <= CALC;
               end
            end
            CALC: begin
               rsp_id_q     <= op_reg.id;
               rsp_data_q   <= op_reg.data;
               rsp_prefix_q <= {par_g, par_f, par_e};
               if (par_g && (odd_cnt != {CW{1'b1}})) odd_cnt <= odd_cnt + CW'(1);
               rsp_valid_q  <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = grant;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_prefix = rsp_prefix_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_parity_arbiter.sv
// Bench for parity_arbiter: scenario tasks against a transaction-level model.
module tb_parity_arbiter;
   import parity_arbiter_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   parity_arbiter_if bus ();
   logic [CW-1:0] odd_cnt;
   logic          busy;
   state_t        state_dbg;

   parity_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .odd_cnt   (odd_cnt),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   int m_last = 3;
   int m_odd  = 0;
   logic [8:0] exp_q[$];   // {id, data, prefix}

   function automatic int model_pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (last + k) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] model_prefix(input logic [3:0] d);
      logic [1:0] lo2;
      logic [2:0] lo3;
      lo2 = d[1:0];
      lo3 = d[2:0];
      return {^d, ^lo3, ^lo2};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_last = 3;
      m_odd  = 0;
      exp_q.delete();
   endtask

   // One full transaction from the current req_valid / req_data, with
   // 'stall' cycles of rsp_ready low in RESP. Caller starts just after an edge.
   task automatic do_txn(input int stall, input bit keep, output int gid);
      int         exp_id;
      logic [3:0] d;
      logic [8:0] exp_w;
      logic [8:0] got_w;
      #1;
      exp_id = model_pick(bus.req_valid, m_last);
      total++;
      if (exp_id < 0 || bus.req_ready !== 4'(1 << exp_id)) begin
         bad++;
         $display("FAIL grant: req_ready=%b expected requester %0d", bus.req_ready, exp_id);
      end
      d = bus.req_data[4*exp_id +: 4];
      exp_q.push_back({2'(exp_id), d, model_prefix(d)});
      bus.rsp_ready = (stall == 0);
      @(posedge clk); #1;
      m_last = exp_id;
      gid    = exp_id;
      if (keep) bus.req_data[4*exp_id +: 4] = 4'($urandom_range(0, 15));
      else      bus.req_valid[exp_id] = 1'b0;
      total++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b1 || bus.req_ready !== 4'b0) begin
         bad++;
         $display("FAIL calc: rsp_valid=%b busy=%b req_ready=%b expected 0 1 0000",
                  bus.rsp_valid, busy, bus.req_ready);
      end
      @(posedge clk); #1;
      exp_w = exp_q.pop_front();
      if (exp_w[2] && m_odd < 255) m_odd++;
      got_w = {bus.rsp_id, bus.rsp_data, bus.rsp_prefix};
      total++;
      if (bus.rsp_valid !== 1'b1 || got_w !== exp_w) begin
         bad++;
         $display("FAIL resp: valid=%b id/data/prefix=%h expected 1 %h",
                  bus.rsp_valid, got_w, exp_w);
      end
      total++;
      if (odd_cnt !== CW'(m_odd)) begin
         bad++;
         $display("FAIL odd_cnt: got %0d expected %0d", odd_cnt, m_odd);
      end
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         total++;
         if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_data, bus.rsp_prefix} !== exp_w ||
             bus.req_ready !== 4'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall: cycle %0d valid=%b word=%h req_ready=%b expected 1 %h 0000",
                     k, bus.rsp_valid, {bus.rsp_id, bus.rsp_data, bus.rsp_prefix},
                     bus.req_ready, exp_w);
         end
      end
      if (stall > 0) bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL release: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'b0 ||
          bus.rsp_data !== 4'b0 || bus.rsp_prefix !== 3'b0 || odd_cnt !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: rr=%b rv=%b id=%0d d=%h p=%b cnt=%0d busy=%b expected all 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_prefix,
                  odd_cnt, busy);
      end
      total++;
      if (state_dbg !== IDLE) begin
         bad++;
         $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
      end
   endtask

   task automatic test_single();
      int gid;
      apply_reset();
      bus.req_valid       = 4'b0100;
      bus.req_data[11:8]  = 4'b1011;
      bus.rsp_ready       = 1'b1;
      do_txn(0, 1'b0, gid);
      total++;
      if (gid !== 2 || odd_cnt !== 8'd1) begin
         bad++;
         $display("FAIL single: id=%0d odd_cnt=%0d expected 2 1", gid, odd_cnt);
      end
   endtask

   task automatic test_all_four();
      int gid;
      apply_reset();
      bus.req_valid = 4'b1111;
      bus.req_data  = 16'hF731;
      for (int i = 0; i < 4; i++) begin
         do_txn(0, 1'b0, gid);
         total++;
         if (gid !== i) begin
            bad++;
            $display("FAIL all_four_order: slot %0d got %0d expected %0d", i, gid, i);
         end
      end
      total++;
      if (odd_cnt !== 8'd2) begin
         bad++;
         $display("FAIL all_four_cnt: got %0d expected 2", odd_cnt);
      end
   endtask

   task automatic test_backpressure();
      int gid;
      apply_reset();
      bus.req_valid     = 4'b0001;
      bus.req_data[3:0] = 4'($urandom_range(0, 15));
      do_txn(10, 1'b0, gid);
   endtask

   task automatic test_rotation();
      int gid;
      int n0;
      int n3;
      n0 = 0;
      n3 = 0;
      apply_reset();
      bus.req_valid = 4'b1001;
      bus.req_data  = 16'($urandom());
      for (int i = 0; i < 20; i++) begin
         do_txn(0, 1'b1, gid);
         if (gid == 0) n0++;
         if (gid == 3) n3++;
         total++;
         if (gid !== ((i % 2 == 1) ? 3 : 0)) begin
            bad++;
            $display("FAIL rotation: txn %0d got %0d expected %0d", i, gid, (i % 2 == 1) ? 3 : 0);
         end
      end
      bus.req_valid = '0;
      total++;
      if (n0 != 10 || n3 != 10) begin
         bad++;
         $display("FAIL rotation_share: n0=%0d n3=%0d expected 10 10", n0, n3);
      end
   endtask

   task automatic test_saturation();
      int gid;
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         bus.req_valid     = 4'b0001;
         bus.req_data[3:0] = 4'h1;
         do_txn(0, 1'b0, gid);
         if (i == 254) begin
            total++;
            if (odd_cnt !== 8'hFF) begin
               bad++;
               $display("FAIL sat_preload: got %0d expected 255", odd_cnt);
            end
         end
      end
      total++;
      if (odd_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL sat_hold: got %0d expected 255", odd_cnt);
      end
   endtask

   task automatic test_reset_mid_resp();
      int gid;
      apply_reset();
      bus.req_valid     = 4'b0001;
      bus.req_data[3:0] = 4'h1;
      bus.rsp_ready     = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || odd_cnt !== 8'd1) begin
         bad++;
         $display("FAIL pre_abort: rsp_valid=%b odd_cnt=%0d expected 1 1", bus.rsp_valid, odd_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.rsp_valid !== 1'b0 || odd_cnt !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort: rsp_valid=%b odd_cnt=%0d busy=%b expected 0 0 0",
                  bus.rsp_valid, odd_cnt, busy);
      end
      @(posedge clk); #1;
      rst_n  = 1'b1;
      m_last = 3;
      m_odd  = 0;
      exp_q.delete();
      bus.req_valid = 4'b0011;
      bus.req_data  = 16'($urandom());
      do_txn(0, 1'b0, gid);
      total++;
      if (gid !== 0) begin
         bad++;
         $display("FAIL post_reset_priority: got %0d expected 0", gid);
      end
      bus.req_valid = '0;
   endtask

   task automatic test_random();
      int gid;
      apply_reset();
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 4; i++) begin
            if (!bus.req_valid[i]) bus.req_data[4*i +: 4] = 4'($urandom_range(0, 15));
         end
         bus.req_valid = bus.req_valid | 4'($urandom_range(0, 15));
         if (bus.req_valid == 4'b0) bus.req_valid = 4'($urandom_range(1, 15));
         do_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), gid);
      end
      bus.req_valid = '0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_rotation();
      test_saturation();
      test_reset_mid_resp();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "time budget exceeded");
   end

endmodule
